// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: groups every pipeline-side hazard input and every
// control output of hazard_ctrl so the core can route them as one bundle.
//
// Parameters
//   AWL  : address width base; register specifiers are AWL-1 bits wide
//   CNTW : width of the stall performance counter carried on StallCount
//
// Modports
//   master : the hazard controller (samples specifiers, drives stall/flush/forward)
//   slave  : the pipeline datapath (drives specifiers, consumes control)
//
// Signals
//   RsD/RtD, RsE/RtE           source specifiers in ID and EX
//   WriteRegE/M/W              destination specifiers in EX/MEM/WB
//   RegWriteE/M/W              register write enables per stage
//   MemtoRegE/M                load present in EX/MEM
//   BranchD, TakenD            conditional branch in ID, resolved taken
//   MultStartE                 multiply/divide op present in EX
//   StallF/D/E, FlushD/E/M     pipeline register hold/clear controls
//   ForwardAE/BE, ForwardAD/BD operand forwarding selects
//   MdBusy, MdDoneE            multi-cycle op status
//   StallCount                 saturating count of front-end stall cycles
interface hazard_ctrl_if #(
  parameter int unsigned AWL  = 6,
  parameter int unsigned CNTW = 16
) ();

  logic [AWL-2:0]  RsD;
  logic [AWL-2:0]  RtD;
  logic [AWL-2:0]  RsE;
  logic [AWL-2:0]  RtE;
  logic [AWL-2:0]  WriteRegE;
  logic [AWL-2:0]  WriteRegM;
  logic [AWL-2:0]  WriteRegW;
  logic            RegWriteE;
  logic            RegWriteM;
  logic            RegWriteW;
  logic            MemtoRegE;
  logic            MemtoRegM;
  logic            BranchD;
  logic            TakenD;
  logic            MultStartE;

  logic            StallF;
  logic            StallD;
  logic            StallE;
  logic            FlushD;
  logic            FlushE;
  logic            FlushM;
  logic [1:0]      ForwardAE;
  logic [1:0]      ForwardBE;
  logic            ForwardAD;
  logic            ForwardBD;
  logic            MdBusy;
  logic            MdDoneE;
  logic [CNTW-1:0] StallCount;

  modport master (
    input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
    input  RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
    input  BranchD, TakenD, MultStartE,
    output StallF, StallD, StallE, FlushD, FlushE, FlushM,
    output ForwardAE, ForwardBE, ForwardAD, ForwardBD,
    output MdBusy, MdDoneE, StallCount
  );

  modport slave (
    output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
    output RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
    output BranchD, TakenD, MultStartE,
    input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
    input  ForwardAE, ForwardBE, ForwardAD, ForwardBD,
    input  MdBusy, MdDoneE, StallCount
  );

endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipelined core.
//
// Produces stall/flush controls for the IF/ID, ID/EX, EX/MEM pipeline
// registers, forwarding selects for the EX and ID operand muxes, sequences
// the multi-cycle multiply/divide unit in EX, and keeps a saturating count
// of cycles in which the PC was held.
//
// Parameters
//   AWL    : address width base; specifiers are AWL-1 bits
//   MD_LAT : EX occupancy of a multiply/divide op in cycles (2..16)
//   CNTW   : StallCount width; must match the bus instance's CNTW
//
// Ports
//   CLK : clock, rising-edge
//   CLR : synchronous active-high reset
//   hz  : hazard_ctrl_if master modport (all hazard inputs and controls)
module hazard_ctrl #(
  parameter int unsigned AWL    = 6,
  parameter int unsigned MD_LAT = 4,
  parameter int unsigned CNTW   = 16
) (
  input  logic         CLK,
  input  logic         CLR,
  hazard_ctrl_if.master hz
);

  localparam int unsigned RW = AWL - 1;

  // First cycle of an op is spent in RUN, so MDWAIT counts down MD_LAT-2 more.
  localparam logic [3:0]      MdLoad = 4'(MD_LAT - 2);
  localparam logic [CNTW-1:0] CntMax = '1;

  typedef enum logic [0:0] {StRun, StMdWait} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [CNTW-1:0] count_q, count_d;

  logic mdstall;
  logic md_done;
  logic lwstall;
  logic brstall;

  // Register 0 is hardwired, so a zero specifier never creates a dependency.
  function automatic logic spec_match(input logic [RW-1:0] a, input logic [RW-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  // Multiply/divide sequencer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mdstall = 1'b0;
    md_done = 1'b0;
    unique case (state_q)
      StRun: begin
        if (hz.MultStartE) begin
          mdstall = 1'b1;
          cnt_d   = MdLoad;
          state_d = StMdWait;
        end
      end
      StMdWait: begin
        // MultStartE is not looked at here: the op already in EX owns the unit.
        if (cnt_q != 4'd0) begin
          mdstall = 1'b1;
          cnt_d   = cnt_q - 4'd1;
        end else begin
          md_done = 1'b1;
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // Data hazards detected in ID
  always_comb begin
    lwstall = hz.MemtoRegE &&
              (spec_match(hz.WriteRegE, hz.RsD) || spec_match(hz.WriteRegE, hz.RtD));
    brstall = hz.BranchD &&
              ((hz.RegWriteE &&
                (spec_match(hz.WriteRegE, hz.RsD) || spec_match(hz.WriteRegE, hz.RtD))) ||
               (hz.MemtoRegM &&
                (spec_match(hz.WriteRegM, hz.RsD) || spec_match(hz.WriteRegM, hz.RtD))));
  end

  // Stall / flush / forward outputs, highest priority first
  always_comb begin
    hz.StallF    = 1'b0;
    hz.StallD    = 1'b0;
    hz.StallE    = 1'b0;
    hz.FlushD    = 1'b0;
    hz.FlushE    = 1'b0;
    hz.FlushM    = 1'b0;
    hz.ForwardAE = 2'b00;
    hz.ForwardBE = 2'b00;
    hz.ForwardAD = 1'b0;
    hz.ForwardBD = 1'b0;
    hz.MdDoneE   = 1'b0;

    if (CLR) begin
      hz.FlushD = 1'b1;
      hz.FlushE = 1'b1;
      hz.FlushM = 1'b1;
    end else begin
      // MEM result is newer than WB, so it wins when both match.
      if (hz.RegWriteM && spec_match(hz.WriteRegM, hz.RsE)) begin
        hz.ForwardAE = 2'b10;
      end else if (hz.RegWriteW && spec_match(hz.WriteRegW, hz.RsE)) begin
        hz.ForwardAE = 2'b01;
      end
      if (hz.RegWriteM && spec_match(hz.WriteRegM, hz.RtE)) begin
        hz.ForwardBE = 2'b10;
      end else if (hz.RegWriteW && spec_match(hz.WriteRegW, hz.RtE)) begin
        hz.ForwardBE = 2'b01;
      end
      hz.ForwardAD = hz.RegWriteM && spec_match(hz.WriteRegM, hz.RsD);
      hz.ForwardBD = hz.RegWriteM && spec_match(hz.WriteRegM, hz.RtD);
      hz.MdDoneE   = md_done;

      if (mdstall) begin
        // Hold F/D/E around the busy op and feed bubbles into MEM.
        hz.StallF = 1'b1;
        hz.StallD = 1'b1;
        hz.StallE = 1'b1;
        hz.FlushM = 1'b1;
      end else if (lwstall || brstall) begin
        hz.StallF = 1'b1;
        hz.StallD = 1'b1;
        hz.FlushE = 1'b1;
      end else if (hz.TakenD) begin
        // Only honoured when ID is not stalled; a stalled branch retries later.
        hz.FlushD = 1'b1;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (hz.StallF && (count_q != CntMax)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= StRun;
      cnt_q   <= 4'd0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
    end
  end

  assign hz.MdBusy     = (state_q == StMdWait);
  assign hz.StallCount = count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
`timescale 1ns/1ps
module tb_hazard_ctrl;

  logic CLK = 1'b0;
  logic CLR;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  // dut0: MD_LAT=4, CNTW=16.  dut1: MD_LAT=2, CNTW=4, same stimulus.
  hazard_ctrl_if #(.AWL(6), .CNTW(16)) bus0 ();
  hazard_ctrl_if #(.AWL(6), .CNTW(4))  bus1 ();

  hazard_ctrl #(.AWL(6), .MD_LAT(4), .CNTW(16)) dut0 (.CLK(CLK), .CLR(CLR), .hz(bus0));
  hazard_ctrl #(.AWL(6), .MD_LAT(2), .CNTW(4))  dut1 (.CLK(CLK), .CLR(CLR), .hz(bus1));

  assign bus1.RsD        = bus0.RsD;
  assign bus1.RtD        = bus0.RtD;
  assign bus1.RsE        = bus0.RsE;
  assign bus1.RtE        = bus0.RtE;
  assign bus1.WriteRegE  = bus0.WriteRegE;
  assign bus1.WriteRegM  = bus0.WriteRegM;
  assign bus1.WriteRegW  = bus0.WriteRegW;
  assign bus1.RegWriteE  = bus0.RegWriteE;
  assign bus1.RegWriteM  = bus0.RegWriteM;
  assign bus1.RegWriteW  = bus0.RegWriteW;
  assign bus1.MemtoRegE  = bus0.MemtoRegE;
  assign bus1.MemtoRegM  = bus0.MemtoRegM;
  assign bus1.BranchD    = bus0.BranchD;
  assign bus1.TakenD     = bus0.TakenD;
  assign bus1.MultStartE = bus0.MultStartE;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus0.RsD = '0; bus0.RtD = '0; bus0.RsE = '0; bus0.RtE = '0;
    bus0.WriteRegE = '0; bus0.WriteRegM = '0; bus0.WriteRegW = '0;
    bus0.RegWriteE = 1'b0; bus0.RegWriteM = 1'b0; bus0.RegWriteW = 1'b0;
    bus0.MemtoRegE = 1'b0; bus0.MemtoRegM = 1'b0;
    bus0.BranchD = 1'b0; bus0.TakenD = 1'b0; bus0.MultStartE = 1'b0;
  endtask

  task automatic rand_inputs();
    bus0.RsD = 5'($urandom); bus0.RtD = 5'($urandom);
    bus0.RsE = 5'($urandom); bus0.RtE = 5'($urandom);
    bus0.WriteRegE = 5'($urandom); bus0.WriteRegM = 5'($urandom);
    bus0.WriteRegW = 5'($urandom);
    bus0.RegWriteE = 1'($urandom); bus0.RegWriteM = 1'($urandom);
    bus0.RegWriteW = 1'($urandom); bus0.MemtoRegE = 1'($urandom);
    bus0.MemtoRegM = 1'($urandom); bus0.BranchD = 1'($urandom);
    bus0.TakenD = 1'($urandom); bus0.MultStartE = 1'($urandom);
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Reset with random inputs
    idle();
    CLR = 1'b1;
    rand_inputs();
    #1;
    check("rst_stallf", bus0.StallF, 0);
    check("rst_stalle", bus0.StallE, 0);
    check("rst_flushes", {bus0.FlushD, bus0.FlushE, bus0.FlushM}, 3'b111);
    check("rst_fwd", {bus0.ForwardAE, bus0.ForwardBE, bus0.ForwardAD, bus0.ForwardBD}, 0);
    check("rst_mddone", bus0.MdDoneE, 0);
    step();
    rand_inputs();
    #1;
    check("rst_count0", bus0.StallCount, 0);
    check("rst_count1", bus1.StallCount, 0);
    check("rst_busy0", bus0.MdBusy, 0);
    check("rst_stalld2", bus0.StallD, 0);
    step();
    CLR = 1'b0;
    idle();
    #1;
    check("rel_flushes", {bus0.FlushD, bus0.FlushE, bus0.FlushM}, 3'b000);
    check("rel_count", bus0.StallCount, 0);

    // Forwarding
    bus0.RegWriteM = 1'b1; bus0.WriteRegM = 5'd5;
    bus0.RegWriteW = 1'b1; bus0.WriteRegW = 5'd5;
    bus0.RsE = 5'd5; bus0.RtE = 5'd0; bus0.RsD = 5'd5;
    #1;
    check("fwd_ae_mem", bus0.ForwardAE, 2'b10);
    check("fwd_be_r0", bus0.ForwardBE, 2'b00);
    check("fwd_ad_mem", bus0.ForwardAD, 1);
    bus0.RegWriteM = 1'b0;
    #1;
    check("fwd_ae_wb", bus0.ForwardAE, 2'b01);
    check("fwd_ad_off", bus0.ForwardAD, 0);
    bus0.RtE = 5'd5; bus0.WriteRegW = 5'd6;
    #1;
    check("fwd_be_none", bus0.ForwardBE, 2'b00);
    check("fwd_ae_none", bus0.ForwardAE, 2'b00);
    bus0.RegWriteM = 1'b1; bus0.WriteRegM = 5'd0; bus0.RsE = 5'd0;
    #1;
    check("fwd_zero_reg", bus0.ForwardAE, 2'b00);
    step();

    // Load-use
    idle();
    bus0.MemtoRegE = 1'b1; bus0.WriteRegE = 5'd8; bus0.RtD = 5'd8;
    #1;
    check("lw_stall", {bus0.StallF, bus0.StallD, bus0.StallE, bus0.FlushE}, 4'b1101);
    check("lw_flushdm", {bus0.FlushD, bus0.FlushM}, 2'b00);
    step();
    check("lw_count", bus0.StallCount, 1);
    bus0.WriteRegE = 5'd0; bus0.RtD = 5'd0;
    #1;
    check("lw_r0_nostall", bus0.StallF, 0);
    step();
    check("lw_count_hold", bus0.StallCount, 1);

    // Branch
    idle();
    bus0.BranchD = 1'b1; bus0.RsD = 5'd3;
    bus0.RegWriteE = 1'b1; bus0.WriteRegE = 5'd3; bus0.TakenD = 1'b1;
    #1;
    check("br_stall", {bus0.StallF, bus0.StallD, bus0.FlushE}, 3'b111);
    check("br_flushd_held", bus0.FlushD, 0);
    step();
    bus0.RegWriteE = 1'b0;
    #1;
    check("br_taken", {bus0.StallF, bus0.FlushD, bus0.FlushE}, 3'b010);
    step();
    check("br_count", bus0.StallCount, 2);
    idle();
    bus0.BranchD = 1'b1; bus0.RtD = 5'd7; bus0.MemtoRegM = 1'b1; bus0.WriteRegM = 5'd7;
    #1;
    check("br_memload", bus0.StallF, 1);
    step();
    bus0.BranchD = 1'b0;
    #1;
    check("nobr_memload", bus0.StallF, 0);
    check("br_count2", bus0.StallCount, 3);

    // Multi-cycle: dut0 MD_LAT=4, dut1 MD_LAT=2 re-launches while held
    idle();
    bus0.MultStartE = 1'b1;
    #1;
    check("md_c1_0", {bus0.StallF, bus0.StallD, bus0.StallE, bus0.FlushM, bus0.FlushE}, 5'b11110);
    check("md_c1_busy", bus0.MdBusy, 0);
    check("md_c1_1", bus1.StallE, 1);
    step();
    check("md_c2_0", {bus0.MdBusy, bus0.StallE, bus0.MdDoneE}, 3'b110);
    check("md_c2_1", {bus1.MdBusy, bus1.StallF, bus1.MdDoneE}, 3'b101);
    step();
    check("md_c3_0", {bus0.MdBusy, bus0.StallF, bus0.FlushM}, 3'b111);
    check("md_c3_1", {bus1.MdBusy, bus1.StallF}, 2'b01);
    step();
    check("md_c4_0", {bus0.MdDoneE, bus0.StallF, bus0.StallD, bus0.StallE}, 4'b1000);
    check("md_c4_1", {bus1.MdDoneE, bus1.StallF}, 2'b10);
    step();
    bus0.MultStartE = 1'b0;
    #1;
    check("md_count0", bus0.StallCount, 6);
    check("md_count1", bus1.StallCount, 5);
    check("md_idle", {bus0.MdBusy, bus1.MdBusy}, 2'b00);

    // Load-use together with MultStartE, then abort dut0 mid-op
    bus0.MultStartE = 1'b1; bus0.MemtoRegE = 1'b1; bus0.WriteRegE = 5'd8; bus0.RsD = 5'd8;
    #1;
    check("mdlw_c1", {bus0.StallE, bus0.FlushE, bus0.FlushM}, 3'b101);
    step();
    bus0.MultStartE = 1'b0;
    #1;
    check("mdlw_c2_0", {bus0.StallE, bus0.FlushE}, 2'b10);
    check("mdlw_c2_1", {bus1.MdDoneE, bus1.StallE, bus1.FlushE, bus1.StallF}, 4'b1011);
    step();
    check("abort_busy_pre", bus0.MdBusy, 1);
    CLR = 1'b1;
    #1;
    check("abort_clr", {bus0.StallF, bus0.FlushD, bus0.MdDoneE}, 3'b010);
    step();
    CLR = 1'b0;
    idle();
    #1;
    check("abort_busy", bus0.MdBusy, 0);
    check("abort_count", bus0.StallCount, 0);

    // Saturation: dut1 has a 4-bit counter
    bus0.MemtoRegE = 1'b1; bus0.WriteRegE = 5'd8; bus0.RtD = 5'd8;
    for (int i = 0; i < 20; i++) step();
    check("sat_count1", bus1.StallCount, 15);
    check("sat_count0", bus0.StallCount, 20);
    step();
    check("sat_hold1", bus1.StallCount, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
